// File: rtl/hazard_pkg.sv
// ============================================================================
// Module : hazard_pkg
// Brief  : Shared widths, types and op classes for the ID-stage hazard unit.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package hazard_pkg;
    localparam int RIDX  = 5;
    localparam int CNT_W = 3;

    typedef logic [RIDX-1:0]  reg_idx_t;
    typedef logic [CNT_W-1:0] lat_t;

    typedef enum logic [1:0] {
        OP_ALU  = 2'd0,
        OP_LOAD = 2'd1,
        OP_LONG = 2'd2
    } op_class_e;
endpackage

`default_nettype wire

// File: rtl/hazard_reg_timer.sv
// ============================================================================
// Module : hazard_reg_timer
// Brief  : Saturating down-counter; a load keeps the larger of the new value
//          and the decremented current value.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module hazard_reg_timer #(
    parameter int CNT_W = 3
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    output logic [CNT_W-1:0] cnt_o
);

    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_dec;

    assign w_dec = (r_cnt == '0) ? '0 : r_cnt - CNT_W'(1);

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_cnt <= '0;
        end else if (load_i && (load_val_i > w_dec)) begin
            r_cnt <= load_val_i;
        end else begin
            r_cnt <= w_dec;
        end
    end

    assign cnt_o = r_cnt;

endmodule

`default_nettype wire

// File: rtl/hazard_scoreboard.sv
// ============================================================================
// Module : hazard_scoreboard
// Brief  : ID-stage countdown scoreboard: data hazards on pending load and
//          mul/div results plus a structural hazard on the long unit.
//          Optional stall-cycle counter enabled by macro HAZARD_PERF_EN.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module hazard_scoreboard #(
    parameter int NREG     = 32,
    parameter int RIDX     = 5,
    parameter int LOAD_LAT = 1,
    parameter int LONG_LAT = 4,
    parameter int CNT_W    = 3
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            id_valid_i,
    input  logic [RIDX-1:0] id_rs1_i,
    input  logic [RIDX-1:0] id_rs2_i,
    input  logic            id_rs1_use_i,
    input  logic            id_rs2_use_i,
    input  logic [RIDX-1:0] id_rd_i,
    input  logic            id_regwr_i,
    input  logic            id_memread_i,
    input  logic            id_long_i,
    input  logic            flush_i,
    output logic            stall_o,
    output logic            pcwrite_o,
    output logic            noop_o,
    output logic [31:0]     stall_cnt_o
);

    import hazard_pkg::*;

    logic [CNT_W-1:0] w_cnt [NREG];
    logic [CNT_W-1:0] w_busy;
    logic [CNT_W-1:0] w_new;
    op_class_e        w_op;
    logic             w_rs1_haz;
    logic             w_rs2_haz;
    logic             w_struct_haz;
    logic             w_stall;
    logic             w_issue;
    logic             w_wr_en;

    always_comb begin
        w_op = OP_ALU;
        if (id_memread_i) begin
            w_op = OP_LOAD;
        end else if (id_long_i) begin
            w_op = OP_LONG;
        end
    end

    always_comb begin
        w_new = '0;
        case (w_op)
            OP_LOAD: w_new = CNT_W'(LOAD_LAT);
            OP_LONG: w_new = CNT_W'(LONG_LAT);
            default: w_new = '0;
        endcase
    end

    assign w_rs1_haz    = id_rs1_use_i && (id_rs1_i != '0) && (w_cnt[id_rs1_i] != '0);
    assign w_rs2_haz    = id_rs2_use_i && (id_rs2_i != '0) && (w_cnt[id_rs2_i] != '0);
    assign w_struct_haz = id_long_i && (w_busy != '0);

    // Flush overrides any hazard: the squashed instruction neither stalls nor issues.
    assign w_stall   = id_valid_i && (w_rs1_haz || w_rs2_haz || w_struct_haz) && !flush_i;
    assign w_issue   = id_valid_i && !w_stall && !flush_i;
    assign w_wr_en   = w_issue && id_regwr_i;

    assign stall_o   = w_stall;
    assign noop_o    = w_stall;
    assign pcwrite_o = !w_stall;

    // x0 is hard-wired to "ready".
    assign w_cnt[0] = '0;

    generate
        for (genvar r = 1; r < NREG; r++) begin : g_reg
            hazard_reg_timer #(
                .CNT_W (CNT_W)
            ) u_timer (
                .clk_i      (clk_i),
                .rst_i      (rst_i),
                .load_i     (w_wr_en && (id_rd_i == RIDX'(r))),
                .load_val_i (w_new),
                .cnt_o      (w_cnt[r])
            );
        end
    endgenerate

    hazard_reg_timer #(
        .CNT_W (CNT_W)
    ) u_long_busy (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .load_i     (w_issue && id_long_i),
        .load_val_i (CNT_W'(LONG_LAT - 1)),
        .cnt_o      (w_busy)
    );

`ifdef HAZARD_PERF_EN
    logic [31:0] r_stall_cnt;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_stall_cnt <= '0;
        end else if (w_stall && (r_stall_cnt != 32'hFFFF_FFFF)) begin
            r_stall_cnt <= r_stall_cnt + 32'd1;
        end
    end

    assign stall_cnt_o = r_stall_cnt;
`else
    assign stall_cnt_o = 32'd0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_hazard_scoreboard.sv
// ============================================================================
// Module : tb_hazard_scoreboard
// Brief  : Cycle-by-cycle table of ID contents with expected stall per cycle,
//          plus a hand-written asynchronous reset sequence.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_hazard_scoreboard;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        id_valid_i;
    logic [4:0]  id_rs1_i;
    logic [4:0]  id_rs2_i;
    logic        id_rs1_use_i;
    logic        id_rs2_use_i;
    logic [4:0]  id_rd_i;
    logic        id_regwr_i;
    logic        id_memread_i;
    logic        id_long_i;
    logic        flush_i;
    logic        stall_o;
    logic        pcwrite_o;
    logic        noop_o;
    logic [31:0] stall_cnt_o;

    hazard_scoreboard dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .id_valid_i   (id_valid_i),
        .id_rs1_i     (id_rs1_i),
        .id_rs2_i     (id_rs2_i),
        .id_rs1_use_i (id_rs1_use_i),
        .id_rs2_use_i (id_rs2_use_i),
        .id_rd_i      (id_rd_i),
        .id_regwr_i   (id_regwr_i),
        .id_memread_i (id_memread_i),
        .id_long_i    (id_long_i),
        .flush_i      (flush_i),
        .stall_o      (stall_o),
        .pcwrite_o    (pcwrite_o),
        .noop_o       (noop_o),
        .stall_cnt_o  (stall_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        string      nm;
        logic       v;
        logic [4:0] rs1;
        logic       u1;
        logic [4:0] rs2;
        logic       u2;
        logic [4:0] rd;
        logic       wr;
        logic       mr;
        logic       lg;
        logic       fl;
        logic       ex;
    } vec_t;

    vec_t tbl[$];
    logic expq[$];
    int   n_chk  = 0;
    int   n_fail = 0;
    int   exp_stalls = 0;

    task automatic add(input string nm, input logic v, input int rs1, input logic u1,
                       input int rs2, input logic u2, input int rd, input logic wr,
                       input logic mr, input logic lg, input logic fl, input logic ex);
        vec_t t;
        t.nm = nm; t.v = v; t.rs1 = 5'(rs1); t.u1 = u1; t.rs2 = 5'(rs2); t.u2 = u2;
        t.rd = 5'(rd); t.wr = wr; t.mr = mr; t.lg = lg; t.fl = fl; t.ex = ex;
        tbl.push_back(t);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) add("idle", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic drive(input vec_t t);
        id_valid_i = t.v; id_rs1_i = t.rs1; id_rs1_use_i = t.u1;
        id_rs2_i = t.rs2; id_rs2_use_i = t.u2; id_rd_i = t.rd;
        id_regwr_i = t.wr; id_memread_i = t.mr; id_long_i = t.lg; flush_i = t.fl;
    endtask

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic check_outs(input string nm, input logic e);
        check(nm, {29'd0, stall_o, pcwrite_o, noop_o}, {29'd0, e, ~e, e});
    endtask

    initial begin
        vec_t t;
        logic e;

        // 1: load-use -> exactly one stall
        add("lw_x5",       1, 0, 0, 0, 0, 5, 1, 1, 0, 0, 0);
        add("lu_stall",    1, 5, 1, 0, 0, 6, 1, 0, 0, 0, 1);
        add("lu_issue",    1, 5, 1, 0, 0, 6, 1, 0, 0, 0, 0);
        idle(5);
        // 2: x0 never tracked, unused rs2 ignored
        add("lw_x0",       1, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0);
        add("rd_x0",       1, 0, 1, 0, 1, 6, 1, 0, 0, 0, 0);
        add("lw_x5b",      1, 0, 0, 0, 0, 5, 1, 1, 0, 0, 0);
        add("rs2_unused",  1, 1, 1, 5, 0, 0, 0, 0, 0, 0, 0);
        idle(5);
        // 3a: mul x7, independent filler, dependent add sees 3 stall cycles
        add("mul_x7",      1, 0, 0, 0, 0, 7, 1, 0, 1, 0, 0);
        add("filler",      1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        add("add_x7_s1",   1, 7, 1, 0, 0, 8, 1, 0, 0, 0, 1);
        add("add_x7_s2",   1, 7, 1, 0, 0, 8, 1, 0, 0, 0, 1);
        add("add_x7_s3",   1, 7, 1, 0, 0, 8, 1, 0, 0, 0, 1);
        add("add_x7_go",   1, 7, 1, 0, 0, 8, 1, 0, 0, 0, 0);
        idle(5);
        // 3b: back-to-back independent mul -> 3 structural stalls
        add("mul_x10",     1, 0, 0, 0, 0, 10, 1, 0, 1, 0, 0);
        add("mul2_s1",     1, 1, 1, 0, 0, 11, 1, 0, 1, 0, 1);
        add("mul2_s2",     1, 1, 1, 0, 0, 11, 1, 0, 1, 0, 1);
        add("mul2_s3",     1, 1, 1, 0, 0, 11, 1, 0, 1, 0, 1);
        add("mul2_go",     1, 1, 1, 0, 0, 11, 1, 0, 1, 0, 0);
        idle(5);
        // 4: flushed dependent long op neither stalls nor marks x14; x13 keeps counting
        add("mul_x13",     1, 0, 0, 0, 0, 13, 1, 0, 1, 0, 0);
        add("flushed",     1, 13, 1, 0, 0, 14, 1, 0, 1, 1, 0);
        add("rd_x14",      1, 14, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        add("rd_x13_s1",   1, 13, 1, 0, 0, 0, 0, 0, 0, 0, 1);
        add("rd_x13_s2",   1, 13, 1, 0, 0, 0, 0, 0, 0, 0, 1);
        add("rd_x13_go",   1, 13, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        idle(5);
        // 5: WAW mul x9 then lw x9 -> longer pending write kept (3 more cycles)
        add("mul_x9",      1, 0, 0, 0, 0, 9, 1, 0, 1, 0, 0);
        add("lw_x9",       1, 0, 0, 0, 0, 9, 1, 1, 0, 0, 0);
        add("rd_x9_s1",    1, 0, 0, 9, 1, 0, 0, 0, 0, 0, 1);
        add("rd_x9_s2",    1, 0, 0, 9, 1, 0, 0, 0, 0, 0, 1);
        add("rd_x9_s3",    1, 0, 0, 9, 1, 0, 0, 0, 0, 0, 1);
        add("rd_x9_go",    1, 0, 0, 9, 1, 0, 0, 0, 0, 0, 0);
        idle(2);

        // reset state
        t = tbl[0];
        t.v = 1'b0;
        drive(t);
        rst_i = 1'b0;
        #1;
        check_outs("reset_outs", 1'b0);
        check("reset_stall_cnt", stall_cnt_o, 32'd0);
        @(negedge clk_i);
        @(negedge clk_i);
        rst_i = 1'b1;

        for (int i = 0; i < tbl.size(); i++) begin
            @(negedge clk_i);
            drive(tbl[i]);
            expq.push_back(tbl[i].ex);
            if (tbl[i].ex) exp_stalls++;
            #1;
            e = expq.pop_front();
            check_outs(tbl[i].nm, e);
        end

        @(negedge clk_i);
`ifdef HAZARD_PERF_EN
        check("stall_cnt_total", stall_cnt_o, 32'(exp_stalls));
`else
        check("stall_cnt_tied", stall_cnt_o, 32'd0);
`endif

        // 6: asynchronous reset in the middle of a mul dependency stall
        add("r_mul_x7",    1, 0, 0, 0, 0, 7, 1, 0, 1, 0, 0);
        add("r_add_x7",    1, 7, 1, 0, 0, 8, 1, 0, 0, 0, 1);
        drive(tbl[tbl.size()-2]);
        @(negedge clk_i);
        drive(tbl[tbl.size()-1]);
        #1;
        check_outs("rst_pre_stall", 1'b1);
        #2;
        rst_i = 1'b0;
        #1;
        check_outs("rst_async_outs", 1'b0);
        check("rst_async_cnt", stall_cnt_o, 32'd0);
        @(negedge clk_i);
        rst_i = 1'b1;
        #1;
        check_outs("rst_sb_cleared", 1'b0);
        @(negedge clk_i);
        check_outs("rst_sb_cleared2", 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
